// File: rtl/divider.sv
// Sequential signed divider: 32-bit dividend / 16-bit divisor -> 16-bit quotient and remainder.
// Radix-2 restoring core, one quotient bit per cycle, with start/busy/done handshake.
module divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] D_i,
  input  logic [15:0] M_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] Q_o,
  output logic [15:0] R_o,
  output logic        dz_o,
  output logic        ovf_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  function automatic logic [15:0] abs16(input logic [15:0] v);
    return v[15] ? (16'd0 - v) : v;
  endfunction

  function automatic logic [15:0] neg16(input logic sel, input logic [15:0] v);
    return sel ? (16'd0 - v) : v;
  endfunction

  state_t      r_state;
  logic        r_sq;
  logic        r_sr;
  logic [15:0] r_abs_m;
  logic [16:0] r_rem;
  logic [15:0] r_q;
  logic [3:0]  r_cnt;
  logic        r_pend_dz;
  logic        r_pend_ovf;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_q_out;
  logic [15:0] r_r_out;
  logic        r_dz;
  logic        r_ovf;

  logic [31:0] w_abs_d;
  logic [15:0] w_abs_m;
  logic [17:0] w_trial;
  logic        w_trial_ok;
  logic [16:0] w_rem_next;
  logic [15:0] w_q_next;
  logic        w_post_ovf;
  logic [15:0] w_res_q;
  logic [15:0] w_res_r;
  logic        w_res_dz;
  logic        w_res_ovf;

  assign w_abs_d = abs32(D_i);
  assign w_abs_m = abs16(M_i);

  // Trial subtraction widened by one bit so its sign bit tells restore from keep.
  assign w_trial    = {1'b0, r_rem[15:0], r_q[15]} - {2'b00, r_abs_m};
  assign w_trial_ok = ~w_trial[17];
  assign w_rem_next = w_trial_ok ? w_trial[16:0] : {r_rem[15:0], r_q[15]};
  assign w_q_next   = {r_q[14:0], w_trial_ok};

  // A negative quotient may reach -32768, a positive one only 32767.
  assign w_post_ovf = r_sq ? (r_q > 16'd32768) : (r_q > 16'd32767);

  // Final result selection applied when the FSM leaves FIN.
  always_comb begin
    w_res_q   = 16'd0;
    w_res_r   = 16'd0;
    w_res_dz  = 1'b0;
    w_res_ovf = 1'b0;
    if (r_pend_dz) begin
      w_res_dz = 1'b1;
    end else if (r_pend_ovf || w_post_ovf) begin
      w_res_ovf = 1'b1;
    end else begin
      w_res_q = neg16(r_sq, r_q);
      w_res_r = neg16(r_sr, r_rem[15:0]);
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sq       <= 1'b0;
      r_sr       <= 1'b0;
      r_abs_m    <= 16'd0;
      r_rem      <= 17'd0;
      r_q        <= 16'd0;
      r_cnt      <= 4'd0;
      r_pend_dz  <= 1'b0;
      r_pend_ovf <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_q_out    <= 16'd0;
      r_r_out    <= 16'd0;
      r_dz       <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_sq    <= D_i[31] ^ M_i[15];
            r_sr    <= D_i[31];
            r_abs_m <= w_abs_m;
            r_rem   <= {1'b0, w_abs_d[31:16]};
            r_q     <= w_abs_d[15:0];
            r_cnt   <= 4'd0;
            r_busy  <= 1'b1;
            if (M_i == 16'd0) begin
              r_pend_dz  <= 1'b1;
              r_pend_ovf <= 1'b0;
              r_state    <= ST_FIN;
            end else if (w_abs_d[31:16] >= w_abs_m) begin
              r_pend_dz  <= 1'b0;
              r_pend_ovf <= 1'b1;
              r_state    <= ST_FIN;
            end else begin
              r_pend_dz  <= 1'b0;
              r_pend_ovf <= 1'b0;
              r_state    <= ST_RUN;
            end
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state <= ST_FIN;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_FIN: begin
          r_q_out <= w_res_q;
          r_r_out <= w_res_r;
          r_dz    <= w_res_dz;
          r_ovf   <= w_res_ovf;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign Q_o    = r_q_out;
  assign R_o    = r_r_out;
  assign dz_o   = r_dz;
  assign ovf_o  = r_ovf;

  divider_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .i_busy   (r_busy),
    .i_done   (r_done),
    .i_dz     (r_dz),
    .i_ovf    (r_ovf),
    .i_rem_hi (r_rem[16])
  );

endmodule

// Structural invariants of the divider handshake and datapath.
module divider_chk (
  input logic clk,
  input logic rst,
  input logic i_busy,
  input logic i_done,
  input logic i_dz,
  input logic i_ovf,
  input logic i_rem_hi
);

  a_done_not_busy: assert property (@(posedge clk) disable iff (rst) i_done |-> !i_busy);
  a_done_pulse:    assert property (@(posedge clk) disable iff (rst) i_done |=> !i_done);
  a_flags_excl:    assert property (@(posedge clk) disable iff (rst) !(i_dz && i_ovf));
  // Partial remainder always stays below the divisor magnitude, so bit 16 is never set.
  a_rem_bound:     assert property (@(posedge clk) disable iff (rst) !i_rem_hi);

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed boundaries, handshake and reset cases,
// plus randomized operands checked against an integer-arithmetic reference model.
module tb_divider;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [31:0] D_i;
  logic [15:0] M_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] Q_o;
  logic [15:0] R_o;
  logic        dz_o;
  logic        ovf_o;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_gaps = 0;

  divider dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .D_i     (D_i),
    .M_i     (M_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .Q_o     (Q_o),
    .R_o     (R_o),
    .dz_o    (dz_o),
    .ovf_o   (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed division with truncation toward zero.
  task automatic model(input logic [31:0] d, input logic [15:0] m,
                       output logic [15:0] eq, output logic [15:0] er,
                       output logic edz, output logic eovf, output int elat);
    longint sd, sm, qq, rr, ad, am;
    sd = longint'($signed(d));
    sm = longint'($signed(m));
    eq = 16'd0; er = 16'd0; edz = 1'b0; eovf = 1'b0; elat = 17;
    if (sm == 0) begin
      edz  = 1'b1;
      elat = 1;
    end else begin
      qq = sd / sm;
      rr = sd % sm;
      ad = (sd < 0) ? -sd : sd;
      am = (sm < 0) ? -sm : sm;
      if (ad >= am * 65536) begin
        eovf = 1'b1;
        elat = 1;
      end else if (qq > 32767 || qq < -32768) begin
        eovf = 1'b1;
      end else begin
        eq = qq[15:0];
        er = rr[15:0];
      end
    end
  endtask

  // Drive a request now; it is accepted at the next rising edge.
  task automatic start_op(input logic [31:0] d, input logic [15:0] m);
    start_i = 1'b1;
    D_i = d;
    M_i = m;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    D_i = $urandom;
    M_i = 16'($urandom);
  endtask

  // Waits for done_o; lat counts rising edges since acceptance (-1 on timeout).
  task automatic wait_done(input int already, output int lat);
    lat = -1;
    for (int k = already + 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        lat = k;
        break;
      end else if (!busy_o) begin
        busy_gaps++;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] d, input logic [15:0] m,
                              input int lat);
    logic [15:0] eq, er;
    logic edz, eovf;
    int elat;
    model(d, m, eq, er, edz, eovf, elat);
    check({tag, ".lat"}, 32'(lat), 32'(elat));
    if (lat > 0) begin
      check({tag, ".Q"}, 32'(Q_o), 32'(eq));
      check({tag, ".R"}, 32'(R_o), 32'(er));
      check({tag, ".dz"}, 32'(dz_o), 32'(edz));
      check({tag, ".ovf"}, 32'(ovf_o), 32'(eovf));
      check({tag, ".busy_at_done"}, 32'(busy_o), 32'd0);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] d, input logic [15:0] m);
    int lat;
    @(negedge clk);
    start_op(d, m);
    check({tag, ".busy_start"}, 32'(busy_o), 32'd1);
    busy_gaps = 0;
    wait_done(0, lat);
    check_result(tag, d, m, lat);
    check({tag, ".busy_held"}, 32'(busy_gaps), 32'd0);
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    int lat;
    int extra;
    logic signed [15:0] a, b;
    longint p;
    logic [31:0] d;
    logic [15:0] m;

    rst = 1'b1; start_i = 1'b0; D_i = 32'd0; M_i = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", 32'(busy_o), 32'd0);
    check("reset.done", 32'(done_o), 32'd0);
    check("reset.Q", 32'(Q_o), 32'd0);
    check("reset.R", 32'(R_o), 32'd0);
    check("reset.flags", 32'({dz_o, ovf_o}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("d100_m7", 32'd100, 16'd7);
    check("d100_m7.Q_abs", 32'(Q_o), 32'd14);
    check("d100_m7.R_abs", 32'(R_o), 32'd2);
    run_op("dm100_m7", -32'sd100, 16'd7);
    check("dm100_m7.Q_abs", 32'(Q_o), 32'h0000_FFF2);
    check("dm100_m7.R_abs", 32'(R_o), 32'h0000_FFFE);
    run_op("d100_mm7", 32'd100, -16'sd7);
    run_op("dm100_mm7", -32'sd100, -16'sd7);
    run_op("inv_min", 32'h4000_0000, 16'h8000);
    check("inv_min.Q_abs", 32'(Q_o), 32'h0000_8000);
    run_op("post_ovf", 32'hC000_0000, 16'h8000);
    check("post_ovf.flag", 32'(ovf_o), 32'd1);
    run_op("dz", 32'h1234_5678, 16'd0);
    check("dz.flag", 32'(dz_o), 32'd1);
    run_op("pre_ovf_max", 32'h7FFF_FFFF, 16'd1);
    run_op("pre_ovf_min", 32'h8000_0000, 16'h8000);
    run_op("exact_zero", 32'd0, 16'd5);

    // Multiplier inverse: (a*b)/b must return a with zero remainder.
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (b == 16'sd0) b = 16'sd3;
      p = longint'(a) * longint'(b);
      d = p[31:0];
      run_op("inverse", d, b);
      check("inverse.Q_eq_a", 32'(Q_o), 32'({16'd0, a}));
      check("inverse.R_zero", 32'(R_o), 32'd0);
    end

    // General random operands, shrunk so both overflow and normal cases occur.
    for (int i = 0; i < 30; i++) begin
      d = $urandom;
      d = 32'($signed(d) >>> $urandom_range(0, 24));
      m = 16'($urandom);
      if ($urandom_range(0, 9) == 0) m = 16'd0;
      run_op("random", d, m);
    end

    // Start pulsed during busy is dropped.
    @(negedge clk);
    start_op(32'd100, 16'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start_i = 1'b1; D_i = 32'd5; M_i = 16'd1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(5, lat);
    check_result("ignore_busy", 32'd100, 16'd7, lat);
    extra = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done_o) extra++;
    end
    check("ignore_busy.extra_done", 32'(extra), 32'd0);

    // Back-to-back: start held in the done cycle is accepted at once.
    @(negedge clk);
    start_op(32'd1000, 16'd9);
    wait_done(0, lat);
    check_result("b2b_first", 32'd1000, 16'd9, lat);
    start_op(-32'sd5000, 16'd33);
    check("b2b.busy_start", 32'(busy_o), 32'd1);
    wait_done(0, lat);
    check_result("b2b_second", -32'sd5000, 16'd33, lat);

    // Reset mid-RUN abandons the operation.
    run_op("pre_reset", 32'd100, 16'd7);
    @(negedge clk);
    start_op(32'd7777, 16'd13);
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid.busy", 32'(busy_o), 32'd0);
    check("rst_mid.done", 32'(done_o), 32'd0);
    check("rst_mid.Q", 32'(Q_o), 32'd0);
    check("rst_mid.R", 32'(R_o), 32'd0);
    check("rst_mid.flags", 32'({dz_o, ovf_o}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done_o || busy_o) extra++;
    end
    check("rst_mid.no_done", 32'(extra), 32'd0);
    run_op("after_reset", 32'd100, 16'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divider.md
# divider

Sequential signed divider for the ALU datapath: divides a signed 32-bit dividend by a signed 16-bit divisor and returns a signed 16-bit quotient and remainder. It is the inverse of the 16x16→32 Booth multiplier: for any product `P = M·N` produced there, dividing `P` by `M ≠ 0` returns `N` with remainder 0. It uses a radix-2 restoring algorithm, one quotient bit per cycle. A start/busy/done handshake connects it to the ALU controller.

## Interface
- Parameters: none; widths are fixed at 32/16.
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst` in 1 — reset, asynchronous, active-high.
- `start_i` in 1 — request; sampled on the rising edge only while `busy_o`=0.
- `D_i` in 32 — signed two's-complement dividend; sampled with `start_i`.
- `M_i` in 16 — signed two's-complement divisor; sampled with `start_i`.
- `busy_o` out 1 — operation in progress; `start_i` is ignored while high.
- `done_o` out 1 — one-cycle pulse; the result outputs are valid from this cycle.
- `Q_o` out 16 — signed quotient, truncated toward zero.
- `R_o` out 16 — signed remainder; its sign follows the dividend, and it is 0 when exact.
- `dz_o` out 1 — divide-by-zero flag, valid with `done_o`.
- `ovf_o` out 1 — quotient-overflow flag, valid with `done_o`.

## Operation
- FSM states: IDLE, RUN, FIN.
- **IDLE, start accepted:**
  - Latch `sq = D_i[31]^M_i[15]` and `sr = D_i[31]`.
  - Latch `aD = |D_i|` as 32-bit unsigned (`0x80000000` is legal) and `aM = |M_i|` as 16-bit unsigned (`0x8000` is legal).
  - If `M_i`=0, set a pending dz and go to FIN.
  - Otherwise, if `aD[31:16] ≥ aM` (pre-check overflow), set a pending ovf and go to FIN.
  - Otherwise load the 17-bit partial remainder `rem={1'b0,aD[31:16]}` and the 16-bit shift register `q=aD[15:0]`, set `cnt=0`, and go to RUN.
- **RUN, each cycle:**
  - Compute `t = {rem[15:0], q[15]} − {1'b0,aM}`, 17 bits.
  - If `t ≥ 0`: `rem←t` and `q←{q[14:0],1}`.
  - Else: `rem←{rem[15:0],q[15]}` and `q←{q[14:0],0}`.
  - Increment `cnt`; after the 16th iteration go to FIN.
- **FIN, one cycle, registers the outputs and pulses `done_o`, then goes to IDLE:**
  - Pending dz: `Q_o`=0, `R_o`=0, `dz_o`=1, `ovf_o`=0.
  - Pending ovf, or post-check failure: `Q_o`=0, `R_o`=0, `dz_o`=0, `ovf_o`=1. The post-check fails when `sq`=0 and `q > 32767`, or when `sq`=1 and `q > 32768`.
  - Otherwise: `Q_o = sq ? −q : q`, `R_o = sr ? −rem[15:0] : rem[15:0]`, `dz_o`=0, `ovf_o`=0.
- Remainder magnitude is always < `aM` ≤ 32768, so `R_o` cannot overflow.
- `Q_o`, `R_o`, `dz_o` and `ovf_o` hold their values until the next FIN. Inputs need not be held after acceptance.
- **Reset:** IDLE; all outputs 0 (`busy_o`, `done_o`, `Q_o`, `R_o`, `dz_o`, `ovf_o`). Reset during RUN or FIN abandons the operation and no `done_o` is produced.

## Timing
- `start_i` is accepted at rising edge t0.
- **Normal path:**
  - `busy_o`=1 from t0 through edge t0+17.
  - `done_o`=1 for exactly one cycle, beginning at edge t0+17, with results valid at that edge.
- **Early exit (dz or pre-check overflow):**
  - `busy_o`=1 from t0 to t0+1.
  - `done_o`=1 beginning at edge t0+1.
- `busy_o` is 0 in the `done_o` cycle. A `start_i` sampled at the end of the done cycle is accepted, giving back-to-back operations with no gap cycle.
- `start_i` asserted while `busy_o`=1 is dropped, not queued.
- `done_o` never asserts without a preceding accepted start.

## Test plan
- D=100, M=7 at t0 → `Q_o`=14, `R_o`=2, flags 0, `done_o` at t0+17 only, `busy_o` high t0..t0+17.
- Sign combinations:
  - D=−100, M=7 → Q=0xFFF2 (−14), R=0xFFFE (−2).
  - D=100, M=−7 → Q=−14, R=2.
  - D=−100, M=−7 → Q=14, R=−2.
- Multiplier inverse and boundaries:
  - D=0x40000000, M=−32768 → Q=0x8000 (−32768), R=0, `ovf_o`=0.
  - D=0xC0000000, M=−32768 → `ovf_o`=1 (post-check), Q=0, R=0, done at t0+17.
  - Random 16-bit pairs (a,b≠0): D=a·b, M=b → Q=a, R=0.
- Early exit:
  - M=0 with any D → `dz_o`=1, Q=R=0, done at t0+1.
  - D=0x7FFFFFFF, M=1 → `ovf_o`=1, done at t0+1.
  - D=0x80000000, M=−32768 → `ovf_o`=1, done at t0+1.
- Handshake:
  - `start_i` pulsed at t0+5 during busy → ignored, exactly one done.
  - `start_i` held in the done cycle → second operation accepted immediately and completes 17 cycles later.
- Reset: assert `rst` asynchronously mid-RUN at t0+8 → all outputs 0 immediately, no `done_o`. After release, D=100, M=7 completes correctly.
